// File: rtl/teletype_out.sv
// Teletype output adapter: turns FIO-DEC characters strobed by the CPU into ASCII bytes.
// The bytes are queued in an 8-deep FIFO for a valid/ready consumer.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   tyo_strobe   CPU request level; a character is taken on its rising edge
//   tyo_char     6-bit FIO-DEC code, stable while tyo_strobe is high
//   tyo_done     one-cycle pulse once the captured character is fully consumed
//   ascii_out    ASCII byte at the FIFO head
//   ascii_valid  FIFO not empty
//   ascii_ready  downstream accepts ascii_out when ascii_valid is also high
//   upper_case   current shift state, 1 = upper
module teletype_out (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tyo_strobe,
  input  logic [5:0] tyo_char,
  output logic       tyo_done,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       upper_case
);

  typedef enum logic [1:0] {StIdle, StXlate, StEmit2, StAck} state_e;
  typedef enum logic [1:0] {KindNone, KindOne, KindCrLf} kind_e;

  state_e      state_q, state_d;
  logic [5:0]  code_q, code_d;
  logic        upper_q, upper_d;
  logic        strobe_q;
  logic        armed_q;
  logic        strobe_edge;

  logic [7:0]  mem [8];
  logic [2:0]  wr_ptr_q, rd_ptr_q;
  logic [3:0]  count_q;
  logic        push, pop, can_push;
  logic [7:0]  push_data;

  kind_e       xl_kind;
  logic [7:0]  xl_byte;

  // armed_q stays low until tyo_strobe has been seen low after reset, so a strobe that is
  // already high when reset releases is not mistaken for a new request.
  assign strobe_edge = tyo_strobe & ~strobe_q & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      armed_q  <= 1'b0;
      state_q  <= StIdle;
      code_q   <= 6'o00;
      upper_q  <= 1'b0;
    end else begin
      strobe_q <= tyo_strobe;
      armed_q  <= armed_q | ~tyo_strobe;
      state_q  <= state_d;
      code_q   <= code_d;
      upper_q  <= upper_d;
    end
  end

  // FIO-DEC to ASCII translation of the latched code under the current shift state.
  always_comb begin
    xl_kind = KindNone;
    xl_byte = 8'h00;
    if (code_q >= 6'o61 && code_q <= 6'o71) begin
      xl_kind = KindOne;
      xl_byte = 8'h61 + {2'b00, code_q - 6'o61} - (upper_q ? 8'h20 : 8'h00);
    end else if (code_q >= 6'o41 && code_q <= 6'o51) begin
      xl_kind = KindOne;
      xl_byte = 8'h6a + {2'b00, code_q - 6'o41} - (upper_q ? 8'h20 : 8'h00);
    end else if (code_q >= 6'o22 && code_q <= 6'o31) begin
      xl_kind = KindOne;
      xl_byte = 8'h73 + {2'b00, code_q - 6'o22} - (upper_q ? 8'h20 : 8'h00);
    end else if (code_q >= 6'o01 && code_q <= 6'o11) begin
      xl_kind = KindOne;
      if (!upper_q) begin
        xl_byte = 8'h31 + {2'b00, code_q - 6'o01};
      end else begin
        case (code_q)
          6'o01:   xl_byte = 8'h22;
          6'o02:   xl_byte = 8'h27;
          6'o03:   xl_byte = 8'h7e;
          6'o04:   xl_byte = 8'h23;
          6'o05:   xl_byte = 8'h21;
          6'o06:   xl_byte = 8'h26;
          6'o07:   xl_byte = 8'h3c;
          6'o10:   xl_byte = 8'h3e;
          default: xl_byte = 8'h5e;
        endcase
      end
    end else begin
      xl_kind = KindOne;
      case (code_q)
        6'o00:   xl_byte = 8'h20;
        6'o36:   xl_byte = 8'h09;
        6'o75:   xl_byte = 8'h08;
        6'o20:   xl_byte = upper_q ? 8'h60 : 8'h30;
        6'o21:   xl_byte = upper_q ? 8'h3f : 8'h2f;
        6'o33:   xl_byte = upper_q ? 8'h3d : 8'h2c;
        6'o73:   xl_byte = upper_q ? 8'h2a : 8'h2e;
        6'o54:   xl_byte = upper_q ? 8'h2b : 8'h2d;
        6'o57:   xl_byte = upper_q ? 8'h5b : 8'h28;
        6'o55:   xl_byte = upper_q ? 8'h5d : 8'h29;
        6'o40:   xl_byte = upper_q ? 8'h5f : 8'h40;
        6'o56:   xl_byte = 8'h7c;
        6'o77: begin
          xl_kind = KindCrLf;
          xl_byte = 8'h0d;
        end
        // Shift, color shift, stop and unassigned codes: acknowledged, nothing pushed.
        default: xl_kind = KindNone;
      endcase
    end
  end

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign pop      = (count_q != 4'd0) & ascii_ready;
  assign can_push = (count_q != 4'd8) | pop;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    upper_d   = upper_q;
    push      = 1'b0;
    push_data = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (strobe_edge) begin
          code_d  = tyo_char;
          state_d = StXlate;
        end
      end
      StXlate: begin
        unique case (xl_kind)
          KindOne: begin
            if (can_push) begin
              push      = 1'b1;
              push_data = xl_byte;
              state_d   = StAck;
            end
          end
          KindCrLf: begin
            if (can_push) begin
              push      = 1'b1;
              push_data = xl_byte;
              state_d   = StEmit2;
            end
          end
          default: begin
            if (code_q == 6'o72) upper_d = 1'b0;
            if (code_q == 6'o74) upper_d = 1'b1;
            state_d = StAck;
          end
        endcase
      end
      StEmit2: begin
        if (can_push) begin
          push      = 1'b1;
          push_data = 8'h0a;
          state_d   = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_q + {3'b000, push} - {3'b000, pop};
    end
  end

  // Storage needs no reset; ascii_out is meaningless while ascii_valid is low.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign ascii_out   = mem[rd_ptr_q];
  assign ascii_valid = (count_q != 4'd0);
  assign tyo_done    = (state_q == StAck);
  assign upper_case  = upper_q;

endmodule

// File: tb/tb_teletype_out.sv
module tb_teletype_out;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tyo_strobe;
  logic [5:0] tyo_char;
  logic       tyo_done;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       upper_case;

  always #5 clk = ~clk;

  teletype_out dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tyo_strobe  (tyo_strobe),
    .tyo_char    (tyo_char),
    .tyo_done    (tyo_done),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .upper_case  (upper_case)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: character tables written straight from the code charts.
  logic [7:0] lo_tab [64];
  logic [7:0] hi_tab [64];
  bit         has_map [64];
  bit         model_up;
  logic [7:0] exp_all [$];
  int         cmp_idx = 0;

  // Filled only by the monitor.
  logic [7:0] obs_all [$];
  int         done_cnt = 0;

  bit rnd_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tyo_done) done_cnt++;
      if (ascii_valid && ascii_ready) obs_all.push_back(ascii_out);
    end
  end

  task automatic put(input int start, input string lo, input string hi);
    for (int i = 0; i < lo.len(); i++) begin
      lo_tab[start+i]  = lo[i];
      hi_tab[start+i]  = hi[i];
      has_map[start+i] = 1'b1;
    end
  endtask

  task automatic build_tables();
    for (int i = 0; i < 64; i++) has_map[i] = 1'b0;
    put('o61, "abcdefghi", "ABCDEFGHI");
    put('o41, "jklmnopqr", "JKLMNOPQR");
    put('o22, "stuvwxyz", "STUVWXYZ");
    put('o01, "123456789", "\"'~#!&<>^");
    put('o20, "0", "0");
    hi_tab['o20] = 8'h60;
    put('o21, "/", "?");
    put('o33, ",", "=");
    put('o73, ".", "*");
    put('o54, "-", "+");
    put('o57, "(", "[");
    put('o55, ")", "]");
    put('o40, "@", "_");
    put('o56, "|", "|");
    put('o00, " ", " ");
    put('o36, "\011", "\011");
    put('o75, "\010", "\010");
  endtask

  task automatic model_char(input logic [5:0] c);
    if (c == 6'o72)      model_up = 1'b0;
    else if (c == 6'o74) model_up = 1'b1;
    else if (c == 6'o77) begin
      exp_all.push_back(8'h0d);
      exp_all.push_back(8'h0a);
    end else if (has_map[c]) exp_all.push_back(model_up ? hi_tab[c] : lo_tab[c]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) ascii_ready = 1'($urandom_range(0, 1));
  endtask

  // Latency counts cycles from the one in which the strobe edge is presented (that cycle = 1).
  task automatic send_char(input logic [5:0] c, output int lat);
    int d0;
    d0 = done_cnt;
    model_char(c);
    tyo_char   = c;
    tyo_strobe = 1'b1;
    lat = 1;
    while (!tyo_done && lat < 200) begin
      tick();
      lat++;
    end
    if (!tyo_done) check_eq("done_timeout", 32'(tyo_done), 32'd1);
    tick();
    tyo_strobe = 1'b0;
    tick();
    check_eq("done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic compare_bytes();
    while (cmp_idx < obs_all.size()) begin
      if (cmp_idx < exp_all.size()) check_eq("byte", obs_all[cmp_idx], exp_all[cmp_idx]);
      else check_eq("extra_byte", obs_all[cmp_idx], 32'h100);
      cmp_idx++;
    end
  endtask

  task automatic drain();
    int n;
    rnd_ready   = 1'b0;
    ascii_ready = 1'b1;
    n = 0;
    while (ascii_valid && n < 100) begin
      tick();
      n++;
    end
    tick();
    check_eq("drained", 32'(ascii_valid), 32'd0);
    compare_bytes();
    check_eq("byte_count", 32'(obs_all.size()), 32'(exp_all.size()));
  endtask

  initial begin
    int lat;
    int d0;
    bit seen;
    logic [5:0] c;

    build_tables();
    model_up    = 1'b0;
    rst_n       = 1'b0;
    tyo_strobe  = 1'b1;  // held high across reset release: must not count as an edge
    tyo_char    = 6'o61;
    ascii_ready = 1'b0;
    #12;
    check_eq("rst_valid", 32'(ascii_valid), 32'd0);
    check_eq("rst_done", 32'(tyo_done), 32'd0);
    check_eq("rst_upper", 32'(upper_case), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("no_edge_at_release", 32'(done_cnt), 32'd0);
    check_eq("no_push_at_release", 32'(ascii_valid), 32'd0);
    tyo_strobe = 1'b0;
    tick();
    tick();

    // Single lower-case letter, latency to tyo_done.
    ascii_ready = 1'b1;
    send_char(6'o61, lat);
    check_eq("latency_a", 32'(lat), 32'd3);
    drain();

    // Shift up / down around a letter.
    send_char(6'o74, lat);
    check_eq("upper_set", 32'(upper_case), 32'd1);
    send_char(6'o61, lat);
    send_char(6'o72, lat);
    check_eq("upper_clr", 32'(upper_case), 32'd0);
    send_char(6'o61, lat);
    drain();

    // CR/LF pair.
    send_char(6'o77, lat);
    check_eq("latency_crlf", 32'(lat), 32'd4);
    drain();

    // Non-printing codes.
    send_char(6'o35, lat);
    check_eq("no_push_o35", 32'(ascii_valid), 32'd0);
    send_char(6'o13, lat);
    check_eq("no_push_o13", 32'(ascii_valid), 32'd0);

    // Fill the FIFO with the consumer stalled, then one more character.
    ascii_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_char(6'(6'o41 + i), lat);
    check_eq("full_valid", 32'(ascii_valid), 32'd1);
    d0 = done_cnt;
    model_char(6'o22);
    tyo_char   = 6'o22;
    tyo_strobe = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tyo_done) seen = 1'b1;
    end
    check_eq("stall_no_done", 32'(seen), 32'd0);
    ascii_ready = 1'b1;
    tick();
    ascii_ready = 1'b0;
    lat = 0;
    while (!tyo_done && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("done_after_pop", 32'(tyo_done), 32'd1);
    tick();
    tyo_strobe = 1'b0;
    tick();
    check_eq("stall_done_once", 32'(done_cnt - d0), 32'd1);
    drain();

    // Reset in the middle of a CR/LF pair, with upper case set.
    send_char(6'o74, lat);
    ascii_ready = 1'b0;
    d0 = done_cnt;
    tyo_char   = 6'o77;
    tyo_strobe = 1'b1;
    tick();
    tick();
    check_eq("cr_pushed", 32'(ascii_valid), 32'd1);
    rst_n = 1'b0;
    model_up = 1'b0;
    #1;
    check_eq("abort_valid", 32'(ascii_valid), 32'd0);
    check_eq("abort_done", 32'(tyo_done), 32'd0);
    check_eq("abort_upper", 32'(upper_case), 32'd0);
    tyo_strobe = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
    ascii_ready = 1'b1;
    send_char(6'o01, lat);
    drain();

    // Random traffic with a randomly stalling consumer.
    rnd_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      c = 6'($urandom_range(0, 63));
      send_char(c, lat);
      check_eq("upper_track", 32'(upper_case), 32'(model_up));
      for (int g = 0; g < $urandom_range(0, 2); g++) tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/teletype_out.md
TELETYPE_OUT -- requirements
Module: teletype_out

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port tyo_strobe  input  1  CPU request: a new FIO-DEC character is present on tyo_char; level signal, acted on at its rising edge.
REQ-004 SHALL have port tyo_char  input  6  FIO-DEC code from the CPU; stable while tyo_strobe is high.
REQ-005 SHALL have port tyo_done  output  1  one-cycle pulse when the captured character has been fully consumed.
REQ-006 SHALL have port ascii_out  output  8  ASCII byte at the FIFO head.
REQ-007 SHALL have port ascii_valid  output  1  FIFO not empty.
REQ-008 SHALL have port ascii_ready  input  1  downstream accepts ascii_out when ascii_valid and ascii_ready are both high.
REQ-009 SHALL have port upper_case  output  1  current shift state; 1 = upper.

Function
REQ-010 SHALL detect a rising edge of tyo_strobe using a registered copy of tyo_strobe, and capture tyo_char on that edge.
REQ-011 SHALL implement the FSM states IDLE, XLATE, EMIT2 and ACK; a strobe edge SHALL be accepted only in IDLE, and edges arriving in any other state SHALL be ignored.
REQ-012 IDLE->XLATE SHALL occur on a strobe edge, with the code latched in that same cycle.
REQ-013 XLATE SHALL translate the code, using upper_case to select between the lower-case and upper-case tables.
REQ-014 XLATE SHALL then proceed as follows:
- push one byte, then go to ACK; or
- push the first byte, then go to EMIT2; or
- push nothing, then go to ACK.
REQ-015 When the FIFO is full, XLATE and EMIT2 SHALL stall (no push, no state change) until a slot frees.
REQ-016 ACK SHALL pulse tyo_done for exactly one cycle, then return to IDLE; minimum strobe-to-done latency is 3 cycles.
REQ-017 Code o72 SHALL clear upper_case, and o74 SHALL set it; neither SHALL push a byte.
REQ-018 Codes o34, o35 (color shift) and o13 (stop) SHALL push nothing.
REQ-019 Code o77 SHALL push 0x0D, then 0x0A in EMIT2.
REQ-020 Codes o00 (0x20), o36 (0x09) and o75 (0x08) SHALL push their ASCII value irrespective of case.
REQ-021 Letters SHALL map as follows, giving 'A'-'Z' when upper_case is set:
- o61-o71 -> 'a'-'i';
- o41-o51 -> 'j'-'r';
- o22-o31 -> 's'-'z'.
REQ-022 Lower-case digits SHALL map o01-o11 -> '1'-'9' and o20 -> '0'.
REQ-023 Upper-case digits SHALL map as follows:
- o01-o11 -> '"', ''', '~', '#', '!', '&', '<', '>', '^';
- o20 -> '`'.
REQ-024 Punctuation SHALL map as lower/upper pairs:
- o21 '/'/'?';
- o33 ','/'=';
- o73 '.'/'*';
- o54 '-'/'+';
- o57 '('/'[';
- o55 ')'/']';
- o40 '@'/'_';
- o56 '|'/'|'.
REQ-025 Every other code SHALL push nothing and SHALL still be acknowledged.
REQ-026 The FIFO SHALL be 8 entries x 8 bits, with 3-bit read/write pointers that wrap modulo 8 and a 4-bit occupancy count (0..8).
REQ-027 A simultaneous push and pop SHALL be legal at any occupancy, including full and empty; the count SHALL be unchanged in that case.
REQ-028 A push SHALL occur only when count < 8, or when count = 8 and a pop happens in the same cycle.
REQ-029 A pop SHALL occur only when ascii_valid is high; ascii_ready while empty SHALL have no effect.
REQ-030 ascii_out SHALL be combinationally the head entry and SHALL hold its value while ascii_ready is low.
REQ-031 Output bytes SHALL leave in strict push order, with no loss or duplication.

Reset
REQ-032 While rst_n is low, all of the following SHALL hold:
- FSM = IDLE;
- pointers = 0, count = 0;
- ascii_valid = 0, tyo_done = 0;
- upper_case = 0;
- strobe edge register = 0.
REQ-033 FIFO storage SHALL need no reset, and ascii_out is don't-care while ascii_valid = 0.
REQ-034 A reset asserted mid-operation SHALL abort the character in flight: no tyo_done SHALL pulse for it and partially pushed CR/LF pairs SHALL be discarded with the FIFO.
REQ-035 If tyo_strobe is already high when rst_n releases, it SHALL NOT be treated as an edge.

Verification
REQ-036 With ascii_ready=1 and lower case, strobe o61 -> 0x61 ('a') on ascii_out, and tyo_done pulses once, 3 cycles after the edge.
REQ-037 Strobe o74, then o61, then o72, then o61 -> output bytes 0x41, 0x61, and upper_case goes 0->1->0.
REQ-038 Strobe o77 with ascii_ready=1 -> output bytes 0x0D, 0x0A in consecutive order and a single tyo_done.
REQ-039 Hold ascii_ready=0 and send 8 letters -> count=8; the 9th strobe gets no tyo_done until ascii_ready pulses once, after which tyo_done fires and the order is preserved across the pointer wrap.
REQ-040 Strobe o35 and o13 -> no bytes pushed, tyo_done pulses for each.
REQ-041 Assert rst_n=0 during EMIT2 of o77 -> FIFO empty, no tyo_done, upper_case=0; a subsequent strobe o01 -> 0x31.
